// File: rtl/ws2812_decoder.sv
// ws2812_decoder: xx6812 one-wire receiver; 24-bit GRB pixel strobes to frame RAM plus frame-gap detection.
// Define WS2812_FORWARD_EN to forward the line on dout once NUM_LEDS pixels have been taken (daisy-chain).
module ws2812_decoder #(
  parameter int NUM_LEDS      = 150,
  parameter int ADDR_WIDTH    = 8,
  parameter int BIT_THRESHOLD = 8,
  parameter int MIN_HIGH      = 2,
  parameter int MAX_HIGH      = 30,
  parameter int RESET_TICKS   = 600
) (
  input  logic                  clock_12mhz,
  input  logic                  reset_n,
  input  logic                  din,
  output logic [23:0]           pixel_data,
  output logic [ADDR_WIDTH-1:0] pixel_addr,
  output logic                  pixel_valid,
  output logic [ADDR_WIDTH-1:0] pixel_count,
  output logic                  frame_done,
  output logic                  error,
  output logic                  dout
);
  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_TICKS + 1);
  localparam logic [HW-1:0] H_MAX = HW'(MAX_HIGH);
  localparam logic [HW-1:0] H_MIN = HW'(MIN_HIGH);
  localparam logic [HW-1:0] H_ONE = HW'(BIT_THRESHOLD);
  localparam logic [LW-1:0] L_END = LW'(RESET_TICKS - 1);
  localparam logic [ADDR_WIDTH-1:0] A_MAX = ADDR_WIDTH'(NUM_LEDS);
  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;
  state_t state;
  logic [1:0] sync_q;
  logic line_q, rise_q, fall_q;
  logic [HW-1:0] high_cnt;
  logic [LW-1:0] low_cnt;
  logic [4:0] bit_cnt;
  logic [22:0] shift_q;
  logic got_bit;
  logic bit_val;
  assign bit_val = high_cnt >= H_ONE;
  // Registered edges keep the strobe a fixed 3 clocks behind the first low sample of din.
  always_ff @(posedge clock_12mhz or negedge reset_n)
    if (!reset_n) begin
      sync_q <= '0;
      line_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      line_q <= sync_q[1];
      rise_q <= sync_q[1] & ~line_q;
      fall_q <= ~sync_q[1] & line_q;
    end
  always_ff @(posedge clock_12mhz or negedge reset_n)
    if (!reset_n) begin
      state       <= SYNC;
      high_cnt    <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      got_bit     <= 1'b0;
      pixel_data  <= '0;
      pixel_addr  <= '0;
      pixel_valid <= 1'b0;
      pixel_count <= '0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      case (state)
        SYNC: begin
          low_cnt <= line_q ? '0 : low_cnt + 1'b1;
          if (!line_q && low_cnt == L_END) state <= IDLE;
        end
        IDLE:
          if (rise_q) begin
            state       <= HIGH;
            high_cnt    <= HW'(1);
            pixel_count <= '0;
            bit_cnt     <= '0;
            got_bit     <= 1'b0;
          end
        HIGH:
          if (high_cnt > H_MAX) begin
            error   <= 1'b1;
            state   <= SYNC;
            low_cnt <= '0;
            bit_cnt <= '0;
          end else if (fall_q) begin
            state   <= LOW;
            low_cnt <= LW'(1);
            if (high_cnt >= H_MIN) begin
              got_bit <= 1'b1;
              shift_q <= {shift_q[21:0], bit_val};
              bit_cnt <= bit_cnt == 5'd23 ? '0 : bit_cnt + 1'b1;
              // Pixels past NUM_LEDS are decoded but never written; the count saturates.
              if (bit_cnt == 5'd23 && pixel_count < A_MAX) begin
                pixel_valid <= 1'b1;
                pixel_data  <= {shift_q, bit_val};
                pixel_addr  <= pixel_count;
                pixel_count <= pixel_count + 1'b1;
              end
            end
          end else high_cnt <= high_cnt + 1'b1;
        LOW:
          if (rise_q) begin
            state    <= HIGH;
            high_cnt <= HW'(1);
          end else if (low_cnt == L_END) begin
            low_cnt    <= low_cnt + 1'b1;
            state      <= IDLE;
            bit_cnt    <= '0;
            error      <= bit_cnt != '0;
            frame_done <= bit_cnt == '0 && got_bit;
          end else low_cnt <= low_cnt + 1'b1;
        default: state <= SYNC;
      endcase
    end
`ifdef WS2812_FORWARD_EN
  always_ff @(posedge clock_12mhz or negedge reset_n)
    if (!reset_n) dout <= 1'b0;
    else dout <= (state == HIGH || state == LOW) && pixel_count == A_MAX ? line_q : 1'b0;
`else
  assign dout = 1'b0;
`endif
endmodule

// File: tb/tb_ws2812_decoder.sv
// tb_ws2812_decoder: randomized pulse trains against a bit/pixel/frame level reference model.
module tb_ws2812_decoder;
  localparam int N = 150;
  logic clock_12mhz = 1'b0;
  logic reset_n = 1'b0;
  logic din = 1'b0;
  logic [23:0] pixel_data;
  logic [7:0] pixel_addr, pixel_count;
  logic pixel_valid, frame_done, error, dout;
  ws2812_decoder dut (
    .clock_12mhz(clock_12mhz),
    .reset_n(reset_n),
    .din(din),
    .pixel_data(pixel_data),
    .pixel_addr(pixel_addr),
    .pixel_valid(pixel_valid),
    .pixel_count(pixel_count),
    .frame_done(frame_done),
    .error(error),
    .dout(dout)
  );
  always #5 clock_12mhz = ~clock_12mhz;
  int cyc = 0;
  always @(posedge clock_12mhz) cyc <= cyc + 1;
  int vectors = 0, miscompares = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  typedef struct {logic [23:0] d; int a; int c;} pix_t;
  pix_t exp_q[$];
  pix_t p;
  int n_strobe = 0, n_fd = 0, n_err = 0, n_dout_rise = 0, n_dout_hi = 0;
  logic dout_q = 1'b0;
  always @(negedge clock_12mhz) begin
    if (pixel_valid) begin
      n_strobe++;
      if (exp_q.size() == 0) check("spurious_strobe", 1, 0);
      else begin
        p = exp_q.pop_front();
        check("pixel_data", pixel_data, p.d);
        check("pixel_addr", pixel_addr, p.a);
        check("strobe_cycle", cyc, p.c);
      end
    end
    n_fd += int'(frame_done);
    n_err += int'(error);
    if (dout && !dout_q) n_dout_rise++;
    n_dout_hi += int'(dout);
    dout_q = dout;
  end
  bit m_sync = 1'b1, m_any = 1'b0, abort = 1'b0;
  int m_bits = 0, m_addr = 0, exp_fd = 0, exp_err = 0, last_cnt = 0;
  logic [23:0] m_sh = '0;
  int s0, f0, e0, d0;
  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clock_12mhz);
    #1;
  endtask
  // One high pulse of w clocks then lo clocks low; the model classifies it as glitch, bit or error.
  task automatic pulse(input int w, input int lo);
    int c;
    if (abort) return;
    hold(1'b1, w);
    c = cyc;
    if (!m_sync) begin
      if (w > 30) begin
        m_sync = 1'b1;
        m_bits = 0;
        exp_err++;
      end else if (w >= 2) begin
        m_sh = {m_sh[22:0], w >= 8};
        m_bits++;
        m_any = 1'b1;
        if (m_bits == 24) begin
          m_bits = 0;
          if (m_addr < N) begin
            exp_q.push_back('{m_sh, m_addr, c + 4});
            m_addr++;
          end
        end
      end
    end
    hold(1'b0, lo);
  endtask
  task automatic gap(input int n);
    hold(1'b0, n);
    if (!m_sync && m_any) begin
      if (m_bits != 0) exp_err++;
      else exp_fd++;
      last_cnt = m_addr;
    end
    m_sync = 1'b0;
    m_bits = 0;
    m_addr = 0;
    m_any = 1'b0;
  endtask
  function automatic int width(input logic b, input int mode);
    case (mode)
      0: return b ? int'($urandom_range(9, 11)) : int'($urandom_range(4, 6));
      1: return b ? 8 : int'($urandom_range(2, 3));
      2: return b ? int'($urandom_range(8, 30)) : int'($urandom_range(2, 7));
      3: return b ? 8 : 7;
      default: return b ? 30 : 2;
    endcase
  endfunction
  function automatic int lowlen(input int mode);
    return mode == 2 ? int'($urandom_range(1, 6)) : (mode >= 3 ? 3 : 1);
  endfunction
  task automatic send_pixel(input logic [23:0] d, input int mode);
    for (int i = 23; i >= 0; i--) begin
      if (mode == 4 || (mode == 2 && $urandom_range(0, 3) == 0)) pulse(1, 2);
      pulse(width(d[i], mode), lowlen(mode));
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_data"}, pixel_data, 0);
    check({tag, "_addr"}, pixel_addr, 0);
    check({tag, "_valid"}, pixel_valid, 0);
    check({tag, "_count"}, pixel_count, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_dout"}, dout, 0);
  endtask
  initial begin
    repeat (3) @(posedge clock_12mhz);
    #1;
    check_idle("reset");
    reset_n = 1'b1;
    gap(700);
    for (int i = 0; i < N; i++) send_pixel(24'hA5C33C, 0);
    gap(700);
    check("pu_strobes", n_strobe, N);
    check("pu_frame_done", n_fd, 1);
    check("pu_count", pixel_count, N);
    check("pu_error", n_err, 0);
    check("pu_pending", exp_q.size(), 0);
    send_pixel(24'h555555, 3);
    gap(700);
    check("cls_data", pixel_data, 24'h555555);
    check("cls_addr", pixel_addr, 0);
    send_pixel(24'h5A5A5A, 4);
    gap(700);
    check("bnd_data", pixel_data, 24'h5A5A5A);
    check("bnd_error", n_err, 0);
    for (int f = 0; f < 3; f++) begin
      s0 = int'($urandom_range(1, 3));
      for (int i = 0; i < s0; i++) send_pixel(24'($urandom), 2);
      gap(700);
      check("rnd_count", pixel_count, last_cnt);
      check("rnd_pending", exp_q.size(), 0);
    end
    s0 = n_strobe;
    f0 = n_fd;
    e0 = n_err;
    reset_n = 1'b0;
    m_sync = 1'b1;
    fork
      for (int i = 0; i < 3; i++) send_pixel(24'($urandom), 1);
      begin
        repeat (200) @(posedge clock_12mhz);
        #2;
        reset_n = 1'b1;
      end
    join
    check("mid_strobes", n_strobe - s0, 0);
    gap(700);
    check("mid_frame_done", n_fd - f0, 0);
    check("mid_error", n_err - e0, 0);
    send_pixel(24'($urandom), 1);
    send_pixel(24'($urandom), 1);
    gap(700);
    check("mid_count", pixel_count, 2);
    check("mid_pending", exp_q.size(), 0);
    f0 = n_fd;
    e0 = n_err;
    s0 = n_strobe;
    for (int i = 0; i < 5; i++) pulse(10, 2);
    pulse(31, 3);
    for (int i = 0; i < 3; i++) pulse(5, 2);
    gap(700);
    check("long_error", n_err - e0, 1);
    check("long_frame_done", n_fd - f0, 0);
    f0 = n_fd;
    e0 = n_err;
    for (int i = 0; i < 10; i++) pulse(width(1'($urandom), 1), 1);
    gap(700);
    check("part_error", n_err - e0, 1);
    check("part_frame_done", n_fd - f0, 0);
    check("part_strobes", n_strobe - s0, 0);
    s0 = n_strobe;
    d0 = n_dout_rise;
    for (int i = 0; i < N + 2; i++) send_pixel(24'($urandom), 1);
    gap(700);
    check("ovf_strobes", n_strobe - s0, N);
    check("ovf_count", pixel_count, N);
`ifdef WS2812_FORWARD_EN
    check("fwd_pulses", n_dout_rise - d0, 48);
`endif
    s0 = n_strobe;
    f0 = n_fd;
    e0 = n_err;
    fork
      for (int i = 0; i < 100; i++) send_pixel(24'($urandom), 1);
      begin
        int t;
        t = 0;
        while (n_strobe - s0 < 70 && t < 30000) begin
          @(posedge clock_12mhz);
          t++;
        end
        check("rst70_reached", t < 30000, 1);
        #1;
        reset_n = 1'b0;
        abort = 1'b1;
        #1;
        check_idle("rst70");
      end
    join
    exp_q.delete();
    m_sync = 1'b1;
    m_bits = 0;
    m_any = 1'b0;
    repeat (5) @(posedge clock_12mhz);
    #1;
    reset_n = 1'b1;
    abort = 1'b0;
    gap(700);
    check("rst70_frame_done", n_fd - f0, 0);
    check("rst70_error", n_err - e0, 0);
    check("frame_done_total", n_fd, exp_fd);
    check("error_total", n_err, exp_err);
`ifndef WS2812_FORWARD_EN
    check("dout_low", n_dout_hi, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
